// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: device-side command endpoint for the UART byte link.
// Decodes host read/write frames arriving on the rx byte stream against an
// internal register bank and returns one response byte per frame on the tx
// stream.
//   Write frame: 0x57, addr, data -> 'K' (0x4B), or 'E' (0x45) if addr out of range
//   Read frame : 0x52, addr       -> reg[addr], or 'E' if addr out of range
//   Other opcode                  -> '?' (0x3F) immediately
// Optional feature (macro UART_CMD_CHKSUM_EN): read/write frames carry a
// trailing XOR checksum byte; a mismatch answers 'C' (0x43) and writes nothing.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   rx_data/valid/ready  received byte stream (responder is sink)
//   tx_data/valid/ready  response byte stream (responder is source)
//   regs_out           flat register bank, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   frame_err          one-cycle pulse when a partial frame times out
module uart_cmd_responder #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned REG_COUNT      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [DATA_WIDTH-1:0]           rx_data,
  input  logic                            rx_valid,
  output logic                            rx_ready,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic [REG_COUNT*DATA_WIDTH-1:0] regs_out,
  output logic                            frame_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int unsigned XW = DATA_WIDTH + 10;

  localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'h57);
  localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'h52);
  localparam logic [DATA_WIDTH-1:0] RSP_OK = DATA_WIDTH'(8'h4B);
  localparam logic [DATA_WIDTH-1:0] RSP_RE = DATA_WIDTH'(8'h45);
  localparam logic [DATA_WIDTH-1:0] RSP_UN = DATA_WIDTH'(8'h3F);
`ifdef UART_CMD_CHKSUM_EN
  localparam logic [DATA_WIDTH-1:0] RSP_CS = DATA_WIDTH'(8'h43);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
`ifdef UART_CMD_CHKSUM_EN
    S_CSUM,
`endif
    S_RESP
  } state_t;

  state_t                r_state;
  logic                  r_is_write;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [CW-1:0]         r_tcnt;
  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic                  r_rx_ready;
  logic                  r_tx_valid;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_frame_err;
`ifdef UART_CMD_CHKSUM_EN
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_csum;
`endif

  logic w_rx_fire;
  logic w_tx_fire;

  assign w_rx_fire = r_rx_ready & rx_valid;
  assign w_tx_fire = r_tx_valid & tx_ready;

  assign rx_ready  = r_rx_ready;
  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign frame_err = r_frame_err;

  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_flat
    assign regs_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
  end

  function automatic logic in_range(input logic [DATA_WIDTH-1:0] a);
    return XW'(a) < XW'(REG_COUNT);
  endfunction

  // Frame decoder, register bank, timeout and response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_is_write  <= 1'b0;
      r_addr      <= '0;
      r_tcnt      <= '0;
      r_rx_ready  <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
`ifdef UART_CMD_CHKSUM_EN
      r_wdata     <= '0;
      r_csum      <= '0;
`endif
    end else begin
      r_frame_err <= 1'b0;

      // Inter-byte timeout while a frame is partially received.
      if (r_state != S_IDLE && r_state != S_RESP) begin
        if (w_rx_fire) begin
          r_tcnt <= '0;
        end else if (r_tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
          r_tcnt      <= '0;
          r_state     <= S_IDLE;
          r_frame_err <= 1'b1;
        end else begin
          r_tcnt <= r_tcnt + CW'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          r_rx_ready <= 1'b1;
          r_tcnt     <= '0;
          if (w_rx_fire) begin
`ifdef UART_CMD_CHKSUM_EN
            r_csum <= rx_data;
`endif
            if (rx_data == OP_WR || rx_data == OP_RD) begin
              r_is_write <= (rx_data == OP_WR);
              r_state    <= S_ADDR;
            end else begin
              r_tx_data  <= RSP_UN;
              r_tx_valid <= 1'b1;
              r_rx_ready <= 1'b0;
              r_state    <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (w_rx_fire) begin
            r_addr <= rx_data;
`ifdef UART_CMD_CHKSUM_EN
            r_csum  <= r_csum ^ rx_data;
            r_state <= r_is_write ? S_DATA : S_CSUM;
`else
            if (r_is_write) begin
              r_state <= S_DATA;
            end else begin
              r_tx_data  <= in_range(rx_data) ? r_regs[AW'(rx_data)] : RSP_RE;
              r_tx_valid <= 1'b1;
              r_rx_ready <= 1'b0;
              r_state    <= S_RESP;
            end
`endif
          end
        end

        S_DATA: begin
          if (w_rx_fire) begin
`ifdef UART_CMD_CHKSUM_EN
            r_wdata <= rx_data;
            r_csum  <= r_csum ^ rx_data;
            r_state <= S_CSUM;
`else
            if (in_range(r_addr)) r_regs[AW'(r_addr)] <= rx_data;
            r_tx_data  <= in_range(r_addr) ? RSP_OK : RSP_RE;
            r_tx_valid <= 1'b1;
            r_rx_ready <= 1'b0;
            r_state    <= S_RESP;
`endif
          end
        end

`ifdef UART_CMD_CHKSUM_EN
        // Checksum gates everything; range is only judged on a clean frame.
        S_CSUM: begin
          if (w_rx_fire) begin
            if (rx_data != r_csum) begin
              r_tx_data <= RSP_CS;
            end else if (!in_range(r_addr)) begin
              r_tx_data <= RSP_RE;
            end else if (r_is_write) begin
              r_regs[AW'(r_addr)] <= r_wdata;
              r_tx_data           <= RSP_OK;
            end else begin
              r_tx_data <= r_regs[AW'(r_addr)];
            end
            r_tx_valid <= 1'b1;
            r_rx_ready <= 1'b0;
            r_state    <= S_RESP;
          end
        end
`endif

        S_RESP: begin
          if (w_tx_fire) begin
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Device-side command endpoint for the UART byte link.
- Consumes received bytes over a valid/ready stream and decodes host read/write command frames against an internal register bank.
- Produces one response byte per frame on a valid/ready stream that feeds the UART transmitter.
- Register contents are exported flat for use by downstream logic.

Parameters:
DATA_WIDTH, 8, byte width of the rx/tx streams and of each register
REG_COUNT, 8, number of registers; valid addresses are 0..REG_COUNT-1 (1..256)
TIMEOUT_CYCLES, 50000, idle clocks allowed between bytes of one frame before it is aborted (>=2)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
rx_data  input  DATA_WIDTH  received byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  responder accepts rx_data
tx_data  output  DATA_WIDTH  response byte
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts tx_data
regs_out  output  REG_COUNT*DATA_WIDTH  register bank; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
frame_err  output  1  one-cycle pulse on timeout abort
- Interface decision: one clock (clk); reset rstn is asynchronous, active-low.

Behaviour:
- Reset values: all registers 0, state IDLE, rx_ready 0 during reset, tx_valid 0, tx_data 0, frame_err 0, timeout counter 0.
- Handshakes: a byte transfers on a rising edge where valid and ready are both 1.
- rx_ready = 1 exactly in IDLE, ADDR, DATA and CSUM; it is 0 in RESP.
- tx_valid = 1 exactly in RESP. tx_data is stable while tx_valid is 1; tx_valid never drops before tx_ready.
- Frames:
  - Write: 0x57, addr, data. Response 0x4B ('K'), or 0x45 ('E') if addr >= REG_COUNT.
  - Read: 0x52, addr. Response is reg[addr], or 0x45 if addr is out of range.
  - Any other opcode: response 0x3F ('?') right after the opcode; no further bytes are consumed.
- Transitions:
  - IDLE --0x57/0x52--> ADDR.
  - IDLE --other--> RESP.
  - ADDR --byte, write--> DATA.
  - ADDR --byte, read--> RESP (or CSUM when the optional feature is enabled).
  - DATA --byte--> RESP (or CSUM).
  - CSUM --byte--> RESP.
  - RESP --tx_ready--> IDLE.
- Latency: tx_valid is 1 in the cycle after the edge that accepts the final frame byte.
- Write commit: the register updates on that same final-byte edge, and only for an in-range, valid frame. An out-of-range write modifies nothing.
- Read sampling: the read value is sampled on the final-byte edge. A simultaneous write is impossible because frames are serial.
- Timeout:
  - The counter runs only in ADDR, DATA and CSUM, and clears on every accepted byte and on entry to IDLE.
  - If it reaches TIMEOUT_CYCLES with no byte accepted, the state returns to IDLE, frame_err pulses for 1 cycle, and no response is sent.
  - No timeout applies in IDLE or RESP; RESP waits for tx_ready indefinitely.
- Bytes that arrive while the responder is in RESP are held off by rx_ready = 0; they are not dropped.
- Reset mid-frame or mid-response: the state clears immediately, tx_valid drops asynchronously, and the partial frame is discarded.

Optional Feature:
- Macro: UART_CMD_CHKSUM_EN.
- Defined: read and write frames carry a trailing checksum byte, the XOR of all preceding frame bytes.
  - On mismatch the response is 0x43 ('C') and no write occurs. The range check applies only when the checksum matches.
  - Unknown opcodes still answer 0x3F immediately, with no checksum byte.
- Undefined: no CSUM state, and the frames are exactly as specified above.

Test Plan:
- Write then read: send 0x57,0x03,0xA5 -> response 0x4B and regs_out[31:24]=0xA5; then send 0x52,0x03 -> response 0xA5.
- Out of range: send 0x57,0x08,0x11 -> response 0x45 and regs_out unchanged; send 0x52,0x09 -> response 0x45.
- Unknown opcode: send 0x00 -> response 0x3F; the next bytes 0x52,0x00 -> response 0x00 (reset value).
- Backpressure: hold tx_ready=0 for 20 cycles after the final byte -> tx_valid and tx_data stable, rx_ready=0, an offered rx byte is not accepted until the response completes.
- Timeout with TIMEOUT_CYCLES=16: send 0x57,0x01 then idle 16 cycles -> frame_err pulse, no tx_valid; then 0x52,0x01 -> response 0x00.
- Checksum (macro defined): send 0x57,0x02,0x5A,0x0F (0x57^0x02^0x5A) -> 0x4B and reg2=0x5A; repeat with final byte 0x00 -> 0x43, reg2 unchanged.
